// File: rtl/mod_updown_counter.sv
// Loadable up/down counter with a runtime modulus (0..limit), a multi-bit step,
// wrap or saturate boundary handling, and carry/overflow flags.
module mod_updown_counter #(
  parameter int N       = 10,
  parameter int STEP_W  = 4,
  parameter int SAT     = 0,
  parameter int RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      limit,
  input  logic              clr_ovf,
  output logic [N-1:0]      out,
  output logic              cout,
  output logic              zero,
  output logic              at_limit,
  output logic              ovf_sticky
);

  // Arithmetic width: wide enough for out + limit + 1 and for the raw step.
  localparam int AW = ((N > STEP_W) ? N : STEP_W) + 1;

  logic [AW-1:0] out_x, lim_x, step_x, ld_x, s_x;
  logic [AW-1:0] up_x, dn_x, wrap_up_x, wrap_dn_x;
  logic [N-1:0]  out_next;
  logic          cout_next;

  assign out_x  = AW'(out);
  assign lim_x  = AW'(limit);
  assign step_x = AW'(step);
  assign ld_x   = AW'(load_val);

  // Effective step: min(step, limit). With limit == 0 a non-zero step is
  // treated as 1 so that the pinned-at-zero counter still reports cout.
  always_comb begin
    s_x = '0;
    if (step_x == '0)
      s_x = '0;
    else if (lim_x == '0)
      s_x = AW'(1);
    else if (step_x < lim_x)
      s_x = step_x;
    else
      s_x = lim_x;
  end

  assign up_x      = out_x + s_x;
  assign dn_x      = out_x - s_x;
  assign wrap_up_x = up_x - lim_x - AW'(1);
  assign wrap_dn_x = out_x + lim_x + AW'(1) - s_x;

  // Next-state selection in priority order load > en > hold.
  always_comb begin
    out_next  = out;
    cout_next = 1'b0;
    if (load) begin
      if (ld_x > lim_x) begin
        out_next  = limit;
        cout_next = 1'b1;
      end else begin
        out_next  = load_val;
      end
    end else if (en) begin
      if (out_x > lim_x) begin
        // Limit was lowered below the current count: clamp back into range.
        out_next  = limit;
        cout_next = 1'b1;
      end else if (!dir) begin
        if (up_x <= lim_x) begin
          out_next = N'(up_x);
        end else begin
          cout_next = 1'b1;
          out_next  = (SAT != 0) ? limit : N'(wrap_up_x);
        end
      end else begin
        if (s_x <= out_x) begin
          out_next = N'(dn_x);
        end else begin
          cout_next = 1'b1;
          out_next  = (SAT != 0) ? '0 : N'(wrap_dn_x);
        end
      end
    end
  end

  // Count, carry pulse and sticky overflow registers; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= N'(RST_VAL);
      cout       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      out  <= out_next;
      cout <= cout_next;
      if (cout_next)
        ovf_sticky <= 1'b1;
      else if (clr_ovf)
        ovf_sticky <= 1'b0;
    end
  end

  assign zero     = (out == '0);
  assign at_limit = (out == limit);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: a wrap-mode and a saturate-mode
// instance share stimulus; expectations come from an integer reference model.
module tb_mod_updown_counter;

  localparam int N      = 10;
  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              rst, en, dir, load, clr_ovf;
  logic [N-1:0]      load_val, limit;
  logic [STEP_W-1:0] step;

  logic [N-1:0] out0, out1;
  logic         cout0, cout1, zero0, zero1, atl0, atl1, ovf0, ovf1;

  always #5 clk = ~clk;

  mod_updown_counter #(.N(N), .STEP_W(STEP_W), .SAT(0), .RST_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .step(step), .limit(limit), .clr_ovf(clr_ovf), .out(out0), .cout(cout0),
    .zero(zero0), .at_limit(atl0), .ovf_sticky(ovf0));

  mod_updown_counter #(.N(N), .STEP_W(STEP_W), .SAT(1), .RST_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .step(step), .limit(limit), .clr_ovf(clr_ovf), .out(out1), .cout(cout1),
    .zero(zero1), .at_limit(atl1), .ovf_sticky(ovf1));

  typedef struct {
    int out;
    bit cout;
    bit zero;
    bit atl;
    bit ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_vec  = 0;
  int n_miss = 0;
  int n_txn  = 0;

  int m_out[2];
  bit m_ovf[2];

  // Reference behaviour written straight from the counting rules.
  function automatic void model(input int sat, input int o, input bit ld, input int lv,
                                input bit e, input bit d, input int st, input int lim,
                                output int no, output bit c);
    int s;
    no = o;
    c  = 1'b0;
    if (ld) begin
      if (lv > lim) begin no = lim; c = 1'b1; end
      else no = lv;
    end else if (e) begin
      if (o > lim) begin
        no = lim; c = 1'b1;
      end else if (st == 0) begin
        no = o;
      end else if (lim == 0) begin
        no = 0; c = 1'b1;
      end else begin
        s = (st < lim) ? st : lim;
        if (!d) begin
          if (o + s <= lim) no = o + s;
          else begin c = 1'b1; no = sat ? lim : o + s - (lim + 1); end
        end else begin
          if (s <= o) no = o - s;
          else begin c = 1'b1; no = sat ? 0 : o + (lim + 1) - s; end
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Drive one cycle of inputs and push the expected post-edge state.
  task automatic apply(input bit r, input bit e, input bit d, input bit ld, input int lv,
                       input int st, input int lim, input bit clr);
    int  no;
    bit  c;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; dir = d; load = ld; load_val = N'(lv);
    step = STEP_W'(st); limit = N'(lim); clr_ovf = clr;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        no = 0; c = 1'b0; m_ovf[i] = 1'b0;
      end else begin
        model(i, m_out[i], ld, lv, e, d, st, lim, no, c);
        if (c) m_ovf[i] = 1'b1;
        else if (clr) m_ovf[i] = 1'b0;
      end
      m_out[i] = no;
      x.out = no; x.cout = c; x.zero = (no == 0); x.atl = (no == lim); x.ovf = m_ovf[i];
      if (i == 0) q0.push_back(x); else q1.push_back(x);
    end
  endtask

  // Monitor: after every edge compare DUT outputs with the oldest expectation.
  always @(posedge clk) begin
    exp_t a;
    exp_t b;
    #1;
    if (q0.size() > 0 && q1.size() > 0) begin
      a = q0.pop_front();
      b = q1.pop_front();
      n_txn++;
      $display("txn %0d: wrap out=%0d cout=%0d ovf=%0d | sat out=%0d cout=%0d ovf=%0d",
               n_txn, out0, cout0, ovf0, out1, cout1, ovf1);
      chk("wrap.out", int'(out0), a.out);
      chk("wrap.cout", int'(cout0), int'(a.cout));
      chk("wrap.zero", int'(zero0), int'(a.zero));
      chk("wrap.at_limit", int'(atl0), int'(a.atl));
      chk("wrap.ovf", int'(ovf0), int'(a.ovf));
      chk("sat.out", int'(out1), b.out);
      chk("sat.cout", int'(cout1), int'(b.cout));
      chk("sat.zero", int'(zero1), int'(b.zero));
      chk("sat.at_limit", int'(atl1), int'(b.atl));
      chk("sat.ovf", int'(ovf1), int'(b.ovf));
    end
  end

  initial begin
    int lim;
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    step = '0; limit = '0; clr_ovf = 1'b0;
    m_out[0] = 0; m_out[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;

    // Reset with en high
    apply(1, 1, 0, 0, 0, 1, 9, 0);
    apply(1, 1, 0, 0, 0, 1, 9, 0);
    // Decade wrap
    for (int k = 0; k < 12; k++) apply(0, 1, 0, 0, 0, 1, 9, 0);
    // Down step wrap from 2
    apply(0, 0, 0, 1, 2, 3, 9, 0);
    apply(0, 1, 1, 0, 0, 3, 9, 0);
    apply(0, 1, 1, 0, 0, 3, 9, 0);
    // Saturate region around 100
    apply(0, 0, 0, 1, 98, 4, 100, 1);
    apply(0, 1, 0, 0, 0, 4, 100, 0);
    apply(0, 1, 0, 0, 0, 4, 100, 0);
    apply(0, 1, 1, 0, 0, 200, 100, 0);
    // Load above limit with clear in the same cycle, then clear alone
    apply(0, 1, 0, 1, 700, 1, 500, 1);
    apply(0, 0, 0, 0, 0, 1, 500, 1);
    apply(1, 1, 0, 1, 300, 1, 500, 0);
    // Limit lowered under the count
    apply(0, 0, 0, 1, 50, 1, 100, 0);
    apply(0, 1, 0, 0, 0, 1, 20, 0);
    apply(0, 1, 0, 0, 0, 1, 20, 0);
    apply(0, 1, 0, 0, 0, 0, 20, 0);
    // limit = 0 pinned, then full-range modulo counting
    apply(0, 1, 0, 0, 0, 5, 0, 0);
    apply(0, 1, 1, 0, 0, 5, 0, 0);
    apply(0, 0, 0, 1, 1020, 0, 1023, 1);
    for (int k = 0; k < 4; k++) apply(0, 1, 0, 0, 0, 3, 1023, 0);
    for (int k = 0; k < 4; k++) apply(0, 1, 1, 0, 0, 7, 1023, 0);

    // Randomised traffic with occasional limit changes
    lim = 9;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 5))
          0: lim = 0;
          1: lim = 1;
          2: lim = 9;
          3: lim = 100;
          4: lim = 1023;
          default: lim = $urandom_range(0, 1023);
        endcase
      end
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 1023),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4),
            lim, $urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drain", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
